// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the shared ALU and its arbiter.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SUB2 = 4'h7;
  localparam logic [3:0] OP_PASS = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: add/sub/shift/logic/pass, no carry or overflow out.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] out
);

  logic shift_sat;

  // in1 is also the shift amount; anything that shifts every bit out gives zero
  assign shift_sat = (in1 >= WIDTH'(WIDTH));

  always_comb begin
    out = '0;
    if (select[3]) begin
      out = in1;
    end else begin
      case (select)
        OP_ADD:          out = in0 + in1;
        OP_SUB, OP_SUB2: out = in0 - in1;
        OP_SHL:          out = shift_sat ? '0 : (in0 << in1);
        OP_SHR:          out = shift_sat ? '0 : (in0 >> in1);
        OP_AND:          out = in0 & in1;
        OP_OR:           out = in0 | in1;
        OP_XOR:          out = in0 ^ in1;
        default:         out = in1;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between NUM_REQ requesters, one op in flight.
//  state   | meaning
//  ST_IDLE | waiting for a request; winner gets req_ready
//  ST_EXEC | ALU evaluating the latched operands
//  ST_RESP | result presented to owner until rsp_ready[grant_id]
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*4-1:0]     req_select,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [WIDTH-1:0] op_in0_q, op_in0_d;
  logic [WIDTH-1:0] op_in1_q, op_in1_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] alu_out;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             win_found;

  alu #(.WIDTH(WIDTH)) u_alu (
    .in0    (op_in0_q),
    .in1    (op_in1_q),
    .select (op_sel_q),
    .out    (alu_out)
  );

  // Search starts just past the last owner so a busy requester cannot starve others
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ST_IDLE && win_found) req_ready = NUM_REQ'(1) << win_id;
    if (state_q == ST_RESP) rsp_valid = NUM_REQ'(1) << grant_id_q;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_in0_d     = op_in0_q;
    op_in1_d     = op_in1_q;
    op_sel_d     = op_sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          op_in0_d     = req_in0[win_id*WIDTH +: WIDTH];
          op_in1_d     = req_in1[win_id*WIDTH +: WIDTH];
          op_sel_d     = req_select[win_id*4 +: 4];
          grant_id_d   = win_id;
          last_grant_d = win_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = alu_out;
        rsp_zero_d = (alu_out == '0);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      op_in0_q     <= '0;
      op_in1_q     <= '0;
      op_sel_q     <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_in0_q     <= op_in0_d;
      op_in1_q     <= op_in1_d;
      op_sel_q     <= op_sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single ops, contention, backpressure, opcodes, withdraw.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic [7:0]  req_select;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        busy;
  logic [0:0]  grant_id;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(16), .NUM_REQ(2), .ID_W(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .req_select (req_select),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] s);
    req_valid[id]        = v;
    req_in0[id*16 +: 16] = a;
    req_in1[id*16 +: 16] = b;
    req_select[id*4 +: 4] = s;
  endtask

  // Full transaction from a lone requester; operands are scrambled after accept
  task automatic run_op(input string tag, input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] s,
                        input logic [15:0] exp_data, input logic exp_zero);
    set_req(id, 1'b1, a, b, s);
    #1;
    chk({tag, ".req_ready"}, req_ready, 32'(2'b01 << id));
    tick();
    set_req(id, 1'b0, 16'hDEAD, 16'hBEEF, 4'h9);
    #1;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".grant_id"}, grant_id, id);
    chk({tag, ".rsp_valid_exec"}, rsp_valid, 0);
    tick();
    chk({tag, ".rsp_valid"}, rsp_valid, 32'(2'b01 << id));
    chk({tag, ".rsp_data"}, rsp_data, exp_data);
    chk({tag, ".rsp_zero"}, rsp_zero, exp_zero);
    rsp_ready[id] = 1'b1;
    tick();
    chk({tag, ".idle"}, busy, 0);
    rsp_ready[id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_in0    = '0;
    req_in1    = '0;
    req_select = '0;
    rsp_ready  = '0;
    #12;
    chk("rst.req_ready", req_ready, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.rsp_zero", rsp_zero, 0);
    chk("rst.busy", busy, 0);
    chk("rst.grant_id", grant_id, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // T2 single ops
    run_op("t2.add", 0, 16'h7FFF, 16'h0001, 4'h0, 16'h8000, 1'b0);
    run_op("t2.wrap", 0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1);

    // T4 backpressure, with a foreign rsp_ready and a competing request during the stall
    set_req(1, 1'b1, 16'h00F0, 16'h0004, 4'h3);
    #1;
    chk("t4.req_ready", req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 16'h0000, 16'h0000, 4'h0);
    tick();
    rsp_ready  = 2'b01;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4.stall_valid", rsp_valid, 2'b10);
      chk("t4.stall_data", rsp_data, 16'h000F);
      chk("t4.stall_ready", req_ready, 0);
      chk("t4.stall_busy", busy, 1);
    end
    req_valid[0] = 1'b0;
    rsp_ready    = 2'b10;
    tick();
    chk("t4.release", busy, 0);
    rsp_ready = 2'b00;

    // T1 reset mid-EXEC
    set_req(1, 1'b1, 16'h1111, 16'h2222, 4'h0);
    tick();
    set_req(1, 1'b0, 16'h0000, 16'h0000, 4'h0);
    #1;
    chk("t1.in_exec", busy, 1);
    chk("t1.grant", grant_id, 1);
    reset_n = 1'b0;
    #1;
    chk("t1.busy", busy, 0);
    chk("t1.grant_id", grant_id, 0);
    chk("t1.rsp_data", rsp_data, 0);
    chk("t1.rsp_valid", rsp_valid, 0);
    chk("t1.req_ready", req_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    chk("t1.no_resp", rsp_valid, 0);

    // T3 contention, both valid and rsp_ready held high
    set_req(0, 1'b1, 16'h1000, 16'h0234, 4'h0);
    set_req(1, 1'b1, 16'h5000, 16'h0001, 4'h1);
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3.req_ready", req_ready, 32'(2'b01 << (k % 2)));
      tick();
      chk("t3.grant_id", grant_id, k % 2);
      chk("t3.exec_no_valid", rsp_valid, 0);
      tick();
      chk("t3.rsp_valid", rsp_valid, 32'(2'b01 << (k % 2)));
      chk("t3.rsp_data", rsp_data, (k % 2 == 1) ? 16'h4FFF : 16'h1234);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;

    // T5 opcode sweep
    run_op("t5.and",  0, 16'h00FF, 16'h0F0F, 4'h4, 16'h000F, 1'b0);
    run_op("t5.or",   0, 16'h00FF, 16'h0F0F, 4'h5, 16'h0FFF, 1'b0);
    run_op("t5.xor",  0, 16'h00FF, 16'h0F0F, 4'h6, 16'h0FF0, 1'b0);
    run_op("t5.sub",  0, 16'h00FF, 16'h0F0F, 4'h1, 16'hF1F0, 1'b0);
    run_op("t5.sub7", 0, 16'h00FF, 16'h0F0F, 4'h7, 16'hF1F0, 1'b0);
    run_op("t5.pass", 0, 16'h00FF, 16'h0F0F, 4'hA, 16'h0F0F, 1'b0);
    run_op("t5.add",  0, 16'h00FF, 16'h0F0F, 4'h0, 16'h100E, 1'b0);
    run_op("t5.shl4", 0, 16'h00FF, 16'h0004, 4'h2, 16'h0FF0, 1'b0);
    run_op("t5.shl16", 0, 16'h00FF, 16'h0010, 4'h2, 16'h0000, 1'b1);
    run_op("t5.shr16", 0, 16'hFFFF, 16'h0010, 4'h3, 16'h0000, 1'b1);

    // T6 withdraw: a pulse between edges in IDLE, and pulses while busy
    @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    chk("t6.ready_pulse", req_ready, 2'b01);
    #2;
    req_valid[0] = 1'b0;
    tick();
    chk("t6.no_capture", busy, 0);
    chk("t6.grant_kept", grant_id, 0);
    set_req(1, 1'b1, 16'h0003, 16'h0002, 4'h2);
    tick();
    set_req(1, 1'b0, 16'h0000, 16'h0000, 4'h0);
    req_valid[0] = 1'b1;
    #1;
    chk("t6.busy_ready", req_ready, 0);
    tick();
    chk("t6.resp_owner", rsp_valid, 2'b10);
    chk("t6.resp_data", rsp_data, 16'h000C);
    req_valid[0] = 1'b0;
    rsp_ready    = 2'b10;
    tick();
    rsp_ready = 2'b00;
    tick();
    tick();
    chk("t6.idle", busy, 0);
    chk("t6.grant_id", grant_id, 1);
    chk("t6.no_resp", rsp_valid, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
